// File: rtl/if_trace_buffer.sv
// IF trace buffer: captures IF tracker records into a FIFO and presents them downstream.
// Optional drop counter port enabled by defining IF_TRACE_DROP_COUNT_EN.
package ryuki_datatypes;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] time_start;
        logic [15:0] time_end;
    } if_trace_t;

    typedef struct packed {
        if_trace_t if_data;
    } trace_output;

endpackage

module if_trace_buffer
    import ryuki_datatypes::*;
#(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_data_ready,
    input  trace_output              if_data_i,
    input  logic                     flush,
    input  logic                     trace_ready,
    output logic                     trace_valid,
    output trace_output              trace_data,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
`ifdef IF_TRACE_DROP_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    trace_output       out_q, out_d;
    logic              overflow_q, overflow_d;
    logic              prev_ready_q, prev_ready_d;
    logic [15:0]       last_te_q, last_te_d;
    trace_output       mem_q [DEPTH];

    logic new_rec;
    logic load;
    logic bypass;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_d        = out_q;
        overflow_d   = overflow_q;
        prev_ready_d = if_data_ready;
        last_te_d    = last_te_q;
        load         = 1'b0;
        bypass       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        drop         = 1'b0;

        new_rec = if_data_ready &&
                  (!prev_ready_q ||
                   (if_data_i.if_data.time_end != last_te_q));
        if (new_rec) begin
            last_te_d = if_data_i.if_data.time_end;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = IDLE;
        end else begin
            // Output register is free when idle or being consumed this cycle
            load = (state_q == IDLE) || trace_ready;
            if (load) begin
                if (count_q != '0) begin
                    out_d   = mem_q[rd_ptr_q];
                    pop     = 1'b1;
                    state_d = PRESENT;
                end else if (new_rec) begin
                    out_d   = if_data_i;
                    bypass  = 1'b1;
                    state_d = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end

            push = new_rec && !bypass && ((count_q != FULL) || pop);
            drop = new_rec && !bypass && !push;

            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_q        <= '0;
            overflow_q   <= 1'b0;
            prev_ready_q <= 1'b0;
            last_te_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_q        <= out_d;
            overflow_q   <= overflow_d;
            prev_ready_q <= prev_ready_d;
            last_te_q    <= last_te_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= if_data_i;
        end
    end

`ifdef IF_TRACE_DROP_COUNT_EN
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign trace_valid = (state_q == PRESENT);
    assign trace_data  = out_q;
    assign overflow    = overflow_q;
    assign fill_level  = count_q + CW'(state_q == PRESENT);

endmodule
